uart_fifo: RTL and testbench

Parametrised UART peripheral with buffered TX/RX FIFOs, runtime-programmable baud divisor and sticky error flags.
- Attaches to the SoC on the single-cycle valid/ready memory port (valid, instr, addr, wdata, wstrb, rdata, ready).
- Drives the board-level uart_rx/uart_tx pins.
- Frame format is fixed 8N1: LSB first, one start bit, one stop bit, no parity.

---
 rtl/uart_fifo.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_uart_fifo.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo.sv
// 8N1 UART peripheral with TX/RX FIFOs, a runtime baud divisor and sticky
// overrun / framing-error flags, attached to a single-cycle valid/ready port.
module uart_fifo #(
    parameter int          TX_DEPTH  = 16,
    parameter int          RX_DEPTH  = 16,
    parameter int          DIV_WIDTH = 16,
    parameter int unsigned DIV_RESET = 868
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        uart_valid,
    input  logic        uart_instr,
    input  logic [31:0] uart_addr,
    input  logic [31:0] uart_wdata,
    input  logic [3:0]  uart_wstrb,
    output logic [31:0] uart_rdata,
    output logic        uart_ready,
    input  logic        uart_rx,
    output logic        uart_tx
);
    localparam int TXAW = $clog2(TX_DEPTH);
    localparam int RXAW = $clog2(RX_DEPTH);
    localparam int TXCW = TXAW + 1;
    localparam int RXCW = RXAW + 1;
    localparam logic [TXAW:0] TX_FULL_CNT = TXCW'(TX_DEPTH);
    localparam logic [RXAW:0] RX_FULL_CNT = RXCW'(RX_DEPTH);
    localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(4);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rxState_t;

    logic                 ready_q;
    logic [31:0]          rdata_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic                 overrun_q, frameErr_q;

    logic [7:0]      txMem [TX_DEPTH];
    logic [TXAW-1:0] txWr_q, txRd_q;
    logic [TXAW:0]   txCount_q;
    logic [7:0]      rxMem [RX_DEPTH];
    logic [RXAW-1:0] rxWr_q, rxRd_q;
    logic [RXAW:0]   rxCount_q;

    txState_t             txState_q, txState_d;
    logic [DIV_WIDTH-1:0] txCnt_q, txCnt_d, txDiv_q, txDiv_d;
    logic [2:0]           txBit_q, txBit_d;
    logic [7:0]           txShift_q, txShift_d;
    logic                 txLine_q, txLine_d;

    rxState_t             rxState_q, rxState_d;
    logic [DIV_WIDTH-1:0] rxCnt_q, rxCnt_d, rxDiv_q, rxDiv_d;
    logic [2:0]           rxBit_q, rxBit_d;
    logic [7:0]           rxShift_q, rxShift_d;
    logic                 rxMeta_q, rxSync_q, rxPrev_q;

    logic        txFull, txEmpty, rxFull, rxEmpty;
    logic        isWrite, txPushReq, stall, accept;
    logic        txPush, txPop, rxPush, rxPop, rxDone;
    logic        frameErrEv, overrunEv, statusRead, divWrite;
    logic [1:0]  regSel;
    logic [31:0] readData;
    logic [DIV_WIDTH-1:0] wdataDiv;
    logic        unusedBits;

    assign unusedBits = ^{uart_instr, uart_addr[31:4], uart_addr[1:0], uart_wdata};

    assign txFull  = (txCount_q == TX_FULL_CNT);
    assign txEmpty = (txCount_q == '0);
    assign rxFull  = (rxCount_q == RX_FULL_CNT);
    assign rxEmpty = (rxCount_q == '0);

    // A TX push into a full FIFO is held off; every other request completes at once.
    assign regSel     = uart_addr[3:2];
    assign isWrite    = |uart_wstrb;
    assign txPushReq  = uart_valid && (regSel == 2'b00) && uart_wstrb[0];
    assign stall      = txPushReq && txFull;
    assign accept     = uart_valid && !ready_q && !stall;
    assign txPush     = accept && txPushReq;
    assign rxPop      = accept && (regSel == 2'b00) && !isWrite && !rxEmpty;
    assign statusRead = accept && (regSel == 2'b01) && !isWrite;
    assign divWrite   = accept && (regSel == 2'b10) && isWrite;
    assign wdataDiv   = uart_wdata[DIV_WIDTH-1:0];

    assign rxPush    = rxDone && (!rxFull || rxPop);
    assign overrunEv = rxDone && rxFull && !rxPop;

    always_comb begin
        readData = '0;
        if (!isWrite) begin
            case (regSel)
                2'b00:   readData = rxEmpty ? 32'h8000_0000 : {24'b0, rxMem[rxRd_q]};
                2'b01:   readData = {26'b0, frameErr_q, overrun_q, rxEmpty, rxFull, txEmpty, txFull};
                2'b10:   readData = 32'(div_q);
                default: readData = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            div_q      <= DIV_WIDTH'(DIV_RESET);
            overrun_q  <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            ready_q <= accept;
            rdata_q <= accept ? readData : '0;
            if (divWrite) div_q <= (wdataDiv < DIV_MIN) ? DIV_MIN : wdataDiv;
            if (overrunEv) overrun_q <= 1'b1;
            else if (statusRead) overrun_q <= 1'b0;
            if (frameErrEv) frameErr_q <= 1'b1;
            else if (statusRead) frameErr_q <= 1'b0;
        end
    end

    assign uart_ready = ready_q;
    assign uart_rdata = rdata_q;

    always_ff @(posedge clock) begin
        if (txPush) txMem[txWr_q] <= uart_wdata[7:0];
        if (rxPush) rxMem[rxWr_q] <= rxShift_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            txWr_q    <= '0;
            txRd_q    <= '0;
            txCount_q <= '0;
            rxWr_q    <= '0;
            rxRd_q    <= '0;
            rxCount_q <= '0;
        end else begin
            if (txPush) txWr_q <= txWr_q + 1'b1;
            if (txPop)  txRd_q <= txRd_q + 1'b1;
            case ({txPush, txPop})
                2'b10:   txCount_q <= txCount_q + 1'b1;
                2'b01:   txCount_q <= txCount_q - 1'b1;
                default: ;
            endcase
            if (rxPush) rxWr_q <= rxWr_q + 1'b1;
            if (rxPop)  rxRd_q <= rxRd_q + 1'b1;
            case ({rxPush, rxPop})
                2'b10:   rxCount_q <= rxCount_q + 1'b1;
                2'b01:   rxCount_q <= rxCount_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Loading from STOP's last cycle lets back-to-back frames run without an idle gap.
    always_comb begin
        txState_d = txState_q;
        txCnt_d   = txCnt_q + 1'b1;
        txDiv_d   = txDiv_q;
        txBit_d   = txBit_q;
        txShift_d = txShift_q;
        txPop     = 1'b0;
        case (txState_q)
            TX_IDLE: begin
                txCnt_d = '0;
                txPop   = !txEmpty;
            end
            TX_START: begin
                if (txCnt_q == txDiv_q - 1'b1) begin
                    txCnt_d   = '0;
                    txBit_d   = '0;
                    txState_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (txCnt_q == txDiv_q - 1'b1) begin
                    txCnt_d   = '0;
                    txShift_d = txShift_q >> 1;
                    if (txBit_q == 3'd7) txState_d = TX_STOP;
                    else txBit_d = txBit_q + 1'b1;
                end
            end
            default: begin
                if (txCnt_q == txDiv_q - 1'b1) begin
                    txCnt_d   = '0;
                    txState_d = TX_IDLE;
                    txPop     = !txEmpty;
                end
            end
        endcase
        if (txPop) begin
            txState_d = TX_START;
            txCnt_d   = '0;
            txShift_d = txMem[txRd_q];
            txDiv_d   = div_q;
        end
        txLine_d = (txState_d == TX_START) ? 1'b0 :
                   (txState_d == TX_DATA)  ? txShift_d[0] : 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            txState_q <= TX_IDLE;
            txCnt_q   <= '0;
            txDiv_q   <= DIV_MIN;
            txBit_q   <= '0;
            txShift_q <= '0;
            txLine_q  <= 1'b1;
        end else begin
            txState_q <= txState_d;
            txCnt_q   <= txCnt_d;
            txDiv_q   <= txDiv_d;
            txBit_q   <= txBit_d;
            txShift_q <= txShift_d;
            txLine_q  <= txLine_d;
        end
    end

    assign uart_tx = txLine_q;

    // Start bit is confirmed at half a bit time; later samples land mid-bit.
    always_comb begin
        rxState_d  = rxState_q;
        rxCnt_d    = rxCnt_q + 1'b1;
        rxDiv_d    = rxDiv_q;
        rxBit_d    = rxBit_q;
        rxShift_d  = rxShift_q;
        rxDone     = 1'b0;
        frameErrEv = 1'b0;
        case (rxState_q)
            RX_IDLE: begin
                rxCnt_d = '0;
                if (rxPrev_q && !rxSync_q) begin
                    rxDiv_d   = div_q;
                    rxState_d = RX_START;
                end
            end
            RX_START: begin
                if (rxCnt_q == (rxDiv_q >> 1) - 1'b1) begin
                    rxCnt_d   = '0;
                    rxBit_d   = '0;
                    rxState_d = rxSync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rxCnt_q == rxDiv_q - 1'b1) begin
                    rxCnt_d   = '0;
                    rxShift_d = {rxSync_q, rxShift_q[7:1]};
                    if (rxBit_q == 3'd7) rxState_d = RX_STOP;
                    else rxBit_d = rxBit_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rxCnt_q == rxDiv_q - 1'b1) begin
                    rxCnt_d = '0;
                    if (rxSync_q) begin
                        rxDone    = 1'b1;
                        rxState_d = RX_IDLE;
                    end else begin
                        frameErrEv = 1'b1;
                        rxState_d  = RX_WAIT_HIGH;
                    end
                end
            end
            default: begin
                rxCnt_d = '0;
                if (rxSync_q) rxState_d = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rxMeta_q  <= 1'b1;
            rxSync_q  <= 1'b1;
            rxPrev_q  <= 1'b1;
            rxState_q <= RX_IDLE;
            rxCnt_q   <= '0;
            rxDiv_q   <= DIV_MIN;
            rxBit_q   <= '0;
            rxShift_q <= '0;
        end else begin
            rxMeta_q  <= uart_rx;
            rxSync_q  <= rxMeta_q;
            rxPrev_q  <= rxSync_q;
            rxState_q <= rxState_d;
            rxCnt_q   <= rxCnt_d;
            rxDiv_q   <= rxDiv_d;
            rxBit_q   <= rxBit_d;
            rxShift_q <= rxShift_d;
        end
    end
endmodule

// File: tb/tb_uart_fifo.sv
// Randomised scoreboard bench for uart_fifo: bus reads are predicted from a
// queue-based model of the FIFOs/flags, and uart_tx frames are decoded cycle by cycle.
module tb_uart_fifo;
    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        uart_valid = 1'b0;
    logic        uart_instr = 1'b0;
    logic [31:0] uart_addr = '0;
    logic [31:0] uart_wdata = '0;
    logic [3:0]  uart_wstrb = '0;
    logic [31:0] uart_rdata;
    logic        uart_ready;
    logic        uart_rx = 1'b1;
    logic        uart_tx;

    always #5 clock = ~clock;

    uart_fifo #(.TX_DEPTH(16), .RX_DEPTH(16), .DIV_WIDTH(16), .DIV_RESET(868)) dut (
        .clock(clock), .reset(reset),
        .uart_valid(uart_valid), .uart_instr(uart_instr), .uart_addr(uart_addr),
        .uart_wdata(uart_wdata), .uart_wstrb(uart_wstrb), .uart_rdata(uart_rdata),
        .uart_ready(uart_ready), .uart_rx(uart_rx), .uart_tx(uart_tx)
    );

    typedef struct {
        bit          isRead;
        logic [31:0] data;
        string       name;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        sbQ[$];
    logic [7:0]  txExpQ[$];
    logic [7:0]  rxModel[$];
    bit          modelOverrun = 1'b0;
    bit          modelFrameErr = 1'b0;
    int          modelDiv = 868;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] statusModel();
        logic [31:0] s;
        s = '0;
        s[1] = 1'b1;
        s[2] = (rxModel.size() == DEPTH);
        s[3] = (rxModel.size() == 0);
        s[4] = modelOverrun;
        s[5] = modelFrameErr;
        return s;
    endfunction

    // Bus master: predict the response, push it to the scoreboard, then run the handshake.
    task automatic applyStimulus(input logic [1:0] regSel, input logic [31:0] wdata,
                                 input logic [3:0] wstrb, input bit allowStall, output int latency);
        exp_t        e;
        logic [31:0] r;
        int          waitCyc;
        waitCyc  = 0;
        e.isRead = (wstrb == 4'b0000);
        e.data   = '0;
        e.name   = "write";
        if (e.isRead) begin
            case (regSel)
                2'b00: begin
                    e.name = "data_read";
                    if (rxModel.size() == 0) e.data = 32'h8000_0000;
                    else e.data = {24'b0, rxModel.pop_front()};
                end
                2'b01: begin
                    e.name = "status_read";
                    e.data = statusModel();
                    modelOverrun  = 1'b0;
                    modelFrameErr = 1'b0;
                end
                2'b10: begin
                    e.name = "divisor_read";
                    e.data = 32'(modelDiv);
                end
                default: e.name = "reserved_read";
            endcase
        end else begin
            if (regSel == 2'b00 && wstrb[0]) txExpQ.push_back(wdata[7:0]);
            if (regSel == 2'b10) modelDiv = (wdata[15:0] < 16'd4) ? 4 : int'(wdata[15:0]);
        end
        sbQ.push_back(e);
        @(posedge clock);
        #1;
        r = $urandom();
        uart_addr  = (r & 32'hFFFF_FFF0) | {28'b0, regSel, 2'b00};
        uart_wdata = wdata;
        uart_wstrb = wstrb;
        uart_instr = 1'($urandom_range(0, 1));
        uart_valid = 1'b1;
        do begin
            @(negedge clock);
            waitCyc++;
        end while (!uart_ready && waitCyc < 5000);
        uart_valid = 1'b0;
        uart_wstrb = '0;
        if (!uart_ready) checkOutput("ready_timeout", 32'(uart_ready), 32'd1);
        else if (!allowStall) checkOutput("ready_latency", 32'(waitCyc), 32'd2);
        latency = waitCyc;
    endtask

    // Scoreboard monitor: every ready pulse consumes one predicted response.
    bit prevReady = 1'b0;
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            prevReady = 1'b0;
        end else begin
            if (uart_ready) begin
                checkOutput("ready_single_pulse", 32'(prevReady), 32'd0);
                if (sbQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_ready: got ready with 0 pending requests, expected none");
                end else begin
                    e = sbQ.pop_front();
                    if (e.isRead) checkOutput(e.name, uart_rdata, e.data);
                end
            end
            prevReady = uart_ready;
        end
    end

    // Serial TX monitor: every cycle of each frame is compared against the ideal 8N1 waveform.
    bit         txMonEn = 1'b1;
    bit         txInFrame = 1'b0;
    bit         burstMode = 1'b0;
    logic       txPrev = 1'b1;
    logic [9:0] txPat = '1;
    int         txCyc = 0, txBad = 0, monDiv = 4;
    int         cyc = 0, lastStart = -1;
    always @(negedge clock) begin
        cyc++;
        if (reset || !txMonEn) begin
            txInFrame = 1'b0;
            txPrev    = 1'b1;
        end else begin
            if (!txInFrame && txPrev && !uart_tx) begin
                if (txExpQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL tx_unexpected_frame: got start bit, expected idle line");
                end else begin
                    txPat     = {1'b1, txExpQ.pop_front(), 1'b0};
                    monDiv    = modelDiv;
                    txInFrame = 1'b1;
                    txCyc     = 0;
                    txBad     = 0;
                    if (burstMode && lastStart >= 0)
                        checkOutput("tx_back_to_back_gap", 32'(cyc - lastStart), 32'(10 * monDiv));
                    lastStart = cyc;
                end
            end
            if (txInFrame) begin
                if (uart_tx !== txPat[txCyc / monDiv]) txBad++;
                txCyc++;
                if (txCyc == 10 * monDiv) begin
                    checkOutput("tx_frame_bad_cycles", 32'(txBad), 32'd0);
                    txInFrame = 1'b0;
                end
            end
            txPrev = uart_tx;
        end
    end

    task automatic waitTxDone();
        int n;
        n = 0;
        while ((txExpQ.size() != 0 || txInFrame) && n < 20000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20000) begin
            checks++;
            errors++;
            $display("[TB] FAIL tx_drain_timeout: got %0d frames pending, expected 0", txExpQ.size());
        end
    endtask

    task automatic sendSerial(input logic [7:0] b, input bit stopLow);
        logic [9:0] bits;
        bits = {~stopLow, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            uart_rx = bits[i];
            repeat (modelDiv - 1) @(negedge clock);
        end
        @(negedge clock);
        uart_rx = 1'b1;
        repeat (3 * modelDiv) @(negedge clock);
        if (stopLow) modelFrameErr = 1'b1;
        else if (rxModel.size() < DEPTH) rxModel.push_back(b);
        else modelOverrun = 1'b1;
    endtask

    task automatic sendGlitch();
        @(negedge clock);
        uart_rx = 1'b0;
        repeat (2) @(negedge clock);
        uart_rx = 1'b1;
        repeat (3 * modelDiv) @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish after 100000 cycles, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        repeat (3) @(negedge clock);
        checkOutput("reset_tx_idle", 32'(uart_tx), 32'd1);
        checkOutput("reset_ready", 32'(uart_ready), 32'd0);
        checkOutput("reset_rdata", uart_rdata, 32'd0);
        reset = 1'b0;

        applyStimulus(2'b01, 32'd0, 4'h0, 1'b0, lat);
        applyStimulus(2'b10, 32'd0, 4'h0, 1'b0, lat);
        applyStimulus(2'b11, 32'd0, 4'h0, 1'b0, lat);
        applyStimulus(2'b11, $urandom(), 4'hF, 1'b0, lat);
        applyStimulus(2'b10, 32'd1, 4'hF, 1'b0, lat);
        applyStimulus(2'b10, 32'd0, 4'h0, 1'b0, lat);
        applyStimulus(2'b00, 32'h0000_00EE, 4'b1110, 1'b0, lat);
        applyStimulus(2'b01, 32'd0, 4'h0, 1'b0, lat);

        applyStimulus(2'b10, 32'd4, 4'hF, 1'b0, lat);
        applyStimulus(2'b00, 32'h0000_0055, 4'h1, 1'b0, lat);
        waitTxDone();

        burstMode = 1'b1;
        lastStart = -1;
        for (int i = 0; i < 18; i++) begin
            applyStimulus(2'b00, $urandom(), 4'h1, (i == 17), lat);
            if (i == 17) checkOutput("tx_full_stall", 32'(lat > 2), 32'd1);
        end
        waitTxDone();
        burstMode = 1'b0;

        applyStimulus(2'b10, 32'd8, 4'hF, 1'b0, lat);
        sendSerial(8'hA3, 1'b0);
        applyStimulus(2'b01, 32'd0, 4'h0, 1'b0, lat);
        applyStimulus(2'b00, 32'd0, 4'h0, 1'b0, lat);
        applyStimulus(2'b00, 32'd0, 4'h0, 1'b0, lat);

        for (int i = 0; i < 17; i++) sendSerial(8'($urandom()), 1'b0);
        applyStimulus(2'b01, 32'd0, 4'h0, 1'b0, lat);
        applyStimulus(2'b01, 32'd0, 4'h0, 1'b0, lat);
        for (int i = 0; i < 17; i++) applyStimulus(2'b00, 32'd0, 4'h0, 1'b0, lat);

        sendSerial(8'($urandom()), 1'b0);
        sendSerial(8'($urandom()), 1'b1);
        applyStimulus(2'b01, 32'd0, 4'h0, 1'b0, lat);
        applyStimulus(2'b00, 32'd0, 4'h0, 1'b0, lat);
        sendGlitch();
        applyStimulus(2'b01, 32'd0, 4'h0, 1'b0, lat);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: sendSerial(8'($urandom()), 1'b0);
                1: sendSerial(8'($urandom()), 1'b1);
                2: sendGlitch();
                3: applyStimulus(2'b00, 32'd0, 4'h0, 1'b0, lat);
                4: begin
                    waitTxDone();
                    applyStimulus(2'b01, 32'd0, 4'h0, 1'b0, lat);
                end
                default: applyStimulus(2'b00, $urandom(), 4'h1, 1'b1, lat);
            endcase
        end
        waitTxDone();

        applyStimulus(2'b00, 32'h0000_005A, 4'h1, 1'b0, lat);
        repeat (4) @(negedge clock);
        checkOutput("tx_frame_in_flight", 32'(uart_tx), 32'd0);
        txMonEn = 1'b0;
        txExpQ.delete();
        reset = 1'b1;
        @(negedge clock);
        checkOutput("reset_abort_tx_high", 32'(uart_tx), 32'd1);
        reset = 1'b0;
        rxModel.delete();
        modelOverrun  = 1'b0;
        modelFrameErr = 1'b0;
        modelDiv      = 868;
        applyStimulus(2'b01, 32'd0, 4'h0, 1'b0, lat);
        applyStimulus(2'b10, 32'd0, 4'h0, 1'b0, lat);
        repeat (3) @(negedge clock);

        if (sbQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending responses, expected 0", sbQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
